// File: rtl/uart_tx_buffer_if.sv
// Byte-stream bus between the upstream writer, the TX buffer and the UART.
// The s_* side accepts bytes and status reads; the m_* side is the Avalon drain.
interface uart_tx_buffer_if;
    logic       s_write;
    logic [7:0] s_writedata;
    logic       s_read;
    logic [7:0] s_readdata;
    logic       m_write;
    logic [7:0] m_writedata;
    logic       m_waitrequest;

    // Environment side: the writer, the status reader and the UART.
    modport master (
        output s_write, s_writedata, s_read, m_waitrequest,
        input  s_readdata, m_write, m_writedata
    );

    // Buffer side.
    modport slave (
        input  s_write, s_writedata, s_read, m_waitrequest,
        output s_readdata, m_write, m_writedata
    );
endinterface

// File: rtl/uart_tx_buffer.sv
// Byte FIFO in front of a UART transmitter, drained over an Avalon write port.
// Sticky overflow flag; the status word is {ovf, full, empty, clipped count}.
module uart_tx_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_buffer_if.slave bus,
    output logic [AW:0]     count
);
    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wp_q, wp_d;
    logic [AW-1:0]   rp_q, rp_d;
    logic [AW:0]     count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      mdata_q, mdata_d;
    logic            full, empty;
    logic            deq, enq, drop;
    logic [4:0]      cnt_clip;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // Drain FSM: pop one byte in IDLE, hold it in SEND until accepted.
    always_comb begin
        state_d = state_q;
        mdata_d = mdata_q;
        deq     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    deq     = 1'b1;
                    mdata_d = mem_q[rp_q];
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!bus.m_waitrequest) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // Pointer, occupancy and overflow update; a same-cycle pop frees a full slot.
    always_comb begin
        enq     = bus.s_write && (!full || deq);
        drop    = bus.s_write && full && !deq;
        wp_d    = enq ? wp_q + AW'(1) : wp_q;
        rp_d    = deq ? rp_q + AW'(1) : rp_q;
        count_d = count_q + {{AW{1'b0}}, enq} - {{AW{1'b0}}, deq};
        ovf_d   = ovf_q;
        if (bus.s_read) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    // Status count saturates at 31 so it fits the 5-bit field.
    always_comb begin
        cnt_clip = 5'd31;
        if (32'(count_q) < 32'd31) begin
            cnt_clip = 5'(count_q);
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            mdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            mdata_q <= mdata_d;
        end
    end

    // Storage array is not reset; only slots below count are ever read.
    always_ff @(posedge clk) begin
        if (rst && enq) begin
            mem_q[wp_q] <= bus.s_writedata;
        end
    end

    assign bus.m_write     = (state_q == SEND);
    assign bus.m_writedata = mdata_q;
    assign bus.s_readdata  = {ovf_q, full, empty, cnt_clip};
    assign count           = count_q;
endmodule

// File: doc/uart_tx_buffer.md
UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 Parameter DEPTH, default 16: FIFO entries; SHALL be a power of two, >= 2.
REQ-002 Parameter AW, default 4: pointer width; SHALL equal log2(DEPTH).
REQ-003 Clocking SHALL be: one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-low reset; sampled only on the clk rising edge.
REQ-006 s_write  input  1  upstream write strobe; one byte per asserted cycle.
REQ-007 s_writedata  input  8  byte to enqueue.
REQ-008 s_read  input  1  status read strobe; clears the sticky overflow flag.
REQ-009 s_readdata  output  8  status word {ovf, full, empty, 5'(count clipped to 31)}.
REQ-010 m_write  output  1  downstream Avalon write request to the uart transmitter.
REQ-011 m_writedata  output  8  byte presented downstream.
REQ-012 m_waitrequest  input  1  downstream stall; the transfer completes on the cycle m_write=1 and m_waitrequest=0.
REQ-013 count  output  AW+1  current FIFO occupancy, 0..DEPTH.

Function
REQ-014 Storage: circular buffer of DEPTH bytes; write pointer wp and read pointer rp, each AW bits; wrap from DEPTH-1 to 0.
REQ-015 empty = (count==0); full = (count==DEPTH); both combinational from registered count.
REQ-016 Enqueue: on s_write=1 with full=0, store s_writedata at wp, then wp+1 and count+1 in the same cycle.
REQ-017 Overflow: on s_write=1 with full=1 and no dequeue in that cycle, drop the byte, leave pointers unchanged, and set ovf=1 next cycle.
REQ-018 ovf is sticky; it clears on s_read=1 unless an overflow occurs in the same cycle, in which case ovf stays 1.
REQ-019 Drain FSM states: IDLE, SEND.
REQ-020 IDLE: m_write=0; if empty=0, load m_writedata from buffer[rp], advance rp, decrement count, and go to SEND.
REQ-021 SEND: m_write=1 and m_writedata held stable; if m_waitrequest=0, the transfer completes and the FSM goes to IDLE; otherwise it stays in SEND.
REQ-022 Transfer spacing: at least one IDLE cycle separates consecutive m_write pulses, so the uart sees each write as a distinct request.
REQ-023 Latency: a byte written into an empty FIFO in IDLE reaches m_write=1 two cycles after the s_write cycle.
REQ-024 Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
REQ-025 Simultaneous enqueue and dequeue while full: the enqueue is accepted (a slot frees that cycle) and ovf is not set.
REQ-026 m_writedata does not change while m_write=1, regardless of s_write.
REQ-027 No combinational path SHALL exist from s_write, s_writedata or m_waitrequest to m_write or m_writedata.

Reset
REQ-028 With rst=0 at a clk edge: wp=0, rp=0, count=0, ovf=0, FSM=IDLE, m_write=0, m_writedata=8'h00.
REQ-029 Buffer contents are not reset; stale data is never output, because reads occur only when count>0.
REQ-030 Reset asserted during SEND aborts the transfer; m_write is 0 in the cycle after the reset edge; the in-flight byte is lost.
REQ-031 s_write and s_read are ignored in any cycle where rst=0.

Verification
REQ-032 Single byte: reset, then s_write 8'hA5 with m_waitrequest=0 -> m_write=1 with 8'hA5 two cycles later, held for one cycle; count returns to 0.
REQ-033 Backpressure: hold m_waitrequest=1 for 10 cycles during SEND -> m_write and m_writedata stay stable all 10 cycles; the transfer completes on the first cycle with m_waitrequest=0.
REQ-034 Fill/overflow: m_waitrequest=1; write 18 bytes 8'h00..8'h11 -> one byte in SEND, full=1, count=16, ovf=1; the drained order is 8'h00..8'h10 and 8'h11 is lost.
REQ-035 Wrap-around: stream 40 incrementing bytes with random m_waitrequest -> the output sequence exactly matches the input; ovf stays 0 when the writer throttles on full.
REQ-036 Overflow flag: after an overflow, s_read -> s_readdata[7]=1 that cycle and 0 next cycle; s_read coincident with an overflowing write -> ovf remains 1.
REQ-037 Mid-transfer reset: assert rst=0 during SEND with count=5 -> the next cycle shows count=0, m_write=0, empty=1.
